can_frame_sequencer: RTL and testbench

//  Bus-level scheduler for the CAN decoder: owns the bus between frame decoder and overload/error frame maker.

---
 rtl/can_frame_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_can_frame_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/can_frame_sequencer.sv
// CAN bus-level scheduler: integration, idle, frame, intermission, error/overload frame launch. All bit logic advances on i_sp; outputs are registered.
// Optional statistics counters (frame/error/overload) are enabled by defining CAN_SEQ_STATS_EN.
module can_frame_sequencer #(
  parameter int IDLE_BITS  = 11,
  parameter int IMS_BITS   = 3,
  parameter int MAX_OVLD   = 2,
  parameter int OE_TIMEOUT = 63
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_rx,
  input  logic        i_sp,
  input  logic        i_error,
  input  logic        i_frame_done,
  input  logic        i_ovld_req,
  input  logic        i_f_itmss,
  output logic        o_f_ovrld,
  output logic        o_oe_type,
  output logic        o_dec_en,
  output logic        o_bus_idle,
  output logic        o_sof,
  output logic        o_oe_tout,
  output logic [2:0]  o_state
`ifdef CAN_SEQ_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_ovld_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_INTEG    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_FRAME    = 3'd2,
    ST_OE_START = 3'd3,
    ST_OE_WAIT  = 3'd4,
    ST_IMS      = 3'd5
  } state_t;

  localparam logic [5:0] C_IDLE_BITS  = 6'(IDLE_BITS);
  localparam logic [5:0] C_IMS_BITS   = 6'(IMS_BITS);
  localparam logic [5:0] C_MAX_OVLD   = 6'(MAX_OVLD);
  localparam logic [5:0] C_OE_TIMEOUT = 6'(OE_TIMEOUT);

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [5:0] r_ovld, w_ovld_nxt, w_ovld_inc;
  logic       r_oe_type, w_oe_type_nxt;
  logic       r_f_ovrld, r_dec_en, r_bus_idle, r_sof, r_oe_tout;
  logic       w_sof, w_tout;

  assign w_cnt_inc  = (r_cnt  == 6'h3F) ? r_cnt  : r_cnt  + 6'd1;
  assign w_ovld_inc = (r_ovld == 6'h3F) ? r_ovld : r_ovld + 6'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ovld_nxt    = r_ovld;
    w_oe_type_nxt = r_oe_type;
    w_sof         = 1'b0;
    w_tout        = 1'b0;
    if (i_sp) begin
      case (r_state)
        ST_INTEG: begin
          if (!i_rx) begin
            w_cnt_nxt = 6'd0;
          end else if (w_cnt_inc >= C_IDLE_BITS) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_IDLE: begin
          if (!i_rx) begin
            w_state_nxt = ST_FRAME;
            w_sof       = 1'b1;
            w_ovld_nxt  = 6'd0;
          end
        end
        ST_FRAME: begin
          // ERROR takes priority over a coincident FRAME_DONE
          if (i_error) begin
            w_state_nxt   = ST_OE_START;
            w_oe_type_nxt = 1'b0;
          end else if (i_frame_done) begin
            if (i_ovld_req && (r_ovld < C_MAX_OVLD)) begin
              w_state_nxt   = ST_OE_START;
              w_oe_type_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IMS;
              w_cnt_nxt   = 6'd0;
            end
          end
        end
        ST_OE_START: begin
          w_state_nxt = ST_OE_WAIT;
          w_cnt_nxt   = 6'd0;
        end
        ST_OE_WAIT: begin
          if (!i_f_itmss) begin
            w_state_nxt = ST_IMS;
            w_cnt_nxt   = 6'd0;
            w_ovld_nxt  = r_oe_type ? w_ovld_inc : 6'd0;
          end else if (w_cnt_inc >= C_OE_TIMEOUT) begin
            w_state_nxt = ST_INTEG;
            w_cnt_nxt   = 6'd0;
            w_tout      = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_IMS: begin
          if (!i_rx) begin
            w_cnt_nxt = 6'd0;
            // dominant in the last intermission bit is a hard sync to a new frame
            if (w_cnt_inc >= C_IMS_BITS) begin
              w_state_nxt = ST_FRAME;
              w_sof       = 1'b1;
              w_ovld_nxt  = 6'd0;
            end else if (r_ovld < C_MAX_OVLD) begin
              w_state_nxt   = ST_OE_START;
              w_oe_type_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_INTEG;
            end
          end else if (w_cnt_inc >= C_IMS_BITS) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_INTEG;
          w_cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_INTEG;
      r_cnt      <= 6'd0;
      r_ovld     <= 6'd0;
      r_oe_type  <= 1'b0;
      r_f_ovrld  <= 1'b1;
      r_dec_en   <= 1'b0;
      r_bus_idle <= 1'b0;
      r_sof      <= 1'b0;
      r_oe_tout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovld     <= w_ovld_nxt;
      r_oe_type  <= w_oe_type_nxt;
      r_f_ovrld  <= (w_state_nxt != ST_OE_START);
      r_dec_en   <= (w_state_nxt == ST_FRAME);
      r_bus_idle <= (w_state_nxt == ST_IDLE);
      r_sof      <= w_sof;
      r_oe_tout  <= w_tout;
    end
  end

  assign o_state    = r_state;
  assign o_f_ovrld  = r_f_ovrld;
  assign o_oe_type  = r_oe_type;
  assign o_dec_en   = r_dec_en;
  assign o_bus_idle = r_bus_idle;
  assign o_sof      = r_sof;
  assign o_oe_tout  = r_oe_tout;

`ifdef CAN_SEQ_STATS_EN
  logic        w_launch;
  logic [15:0] r_frame_cnt, r_err_cnt, r_ovld_cnt;

  assign w_launch = (w_state_nxt == ST_OE_START) && (r_state != ST_OE_START);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
      r_ovld_cnt  <= 16'd0;
    end else begin
      if (w_sof)                      r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_launch && !w_oe_type_nxt) r_err_cnt   <= r_err_cnt + 16'd1;
      if (w_launch && w_oe_type_nxt)  r_ovld_cnt  <= r_ovld_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_ovld_cnt  = r_ovld_cnt;
`endif

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed bench for can_frame_sequencer; statistics checks compile in when CAN_SEQ_STATS_EN is defined.
module tb_can_frame_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1, sp = 1'b0, error = 1'b0, frame_done = 1'b0, ovld_req = 1'b0, f_itmss = 1'b1;
  logic       f_ovrld, oe_type, dec_en, bus_idle, sof, oe_tout;
  logic [2:0] state;
`ifdef CAN_SEQ_STATS_EN
  logic [15:0] frame_cnt, err_cnt, ovld_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  can_frame_sequencer dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx(rx), .i_sp(sp), .i_error(error),
    .i_frame_done(frame_done), .i_ovld_req(ovld_req), .i_f_itmss(f_itmss),
    .o_f_ovrld(f_ovrld), .o_oe_type(oe_type), .o_dec_en(dec_en), .o_bus_idle(bus_idle),
    .o_sof(sof), .o_oe_tout(oe_tout), .o_state(state)
`ifdef CAN_SEQ_STATS_EN
    , .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt), .o_ovld_cnt(ovld_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One SP strobe with the given bus level; returns on the falling edge after the SP clock edge.
  task automatic do_sp(input logic lvl);
    @(negedge clk);
    rx = lvl;
    sp = 1'b1;
    @(negedge clk);
    sp = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_state", 16'(state), 16'd0);
    check("rst_f_ovrld", 16'(f_ovrld), 16'd1);
    check("rst_oe_type", 16'(oe_type), 16'd0);
    check("rst_dec_en", 16'(dec_en), 16'd0);
    check("rst_bus_idle", 16'(bus_idle), 16'd0);
    check("rst_sof", 16'(sof), 16'd0);
    check("rst_oe_tout", 16'(oe_tout), 16'd0);
    rst_n = 1'b1;

    // integration: dominant on bit 7 restarts the count, idle after 18 SP
    repeat (6) do_sp(1'b1);
    do_sp(1'b0);
    repeat (10) do_sp(1'b1);
    check("integ_17_state", 16'(state), 16'd0);
    check("integ_17_idle", 16'(bus_idle), 16'd0);
    do_sp(1'b1);
    check("integ_18_state", 16'(state), 16'd1);
    check("integ_18_idle", 16'(bus_idle), 16'd1);

    // frame 1: SOF, decode, FRAME_DONE, intermission back to idle
    do_sp(1'b0);
    check("sof1_pulse", 16'(sof), 16'd1);
    check("sof1_dec_en", 16'(dec_en), 16'd1);
    check("sof1_state", 16'(state), 16'd2);
    check("sof1_idle", 16'(bus_idle), 16'd0);
    @(negedge clk);
    check("sof1_pulse_end", 16'(sof), 16'd0);
    repeat (3) do_sp(1'b1);
    check("frame1_hold", 16'(state), 16'd2);
    frame_done = 1'b1;
    do_sp(1'b1);
    frame_done = 1'b0;
    check("fdone_state", 16'(state), 16'd5);
    check("fdone_dec_en", 16'(dec_en), 16'd0);
    repeat (2) do_sp(1'b1);
    check("ims2_state", 16'(state), 16'd5);
    do_sp(1'b1);
    check("ims3_state", 16'(state), 16'd1);

    // frame 2: ERROR and FRAME_DONE together -> error frame
    do_sp(1'b0);
    check("sof2_state", 16'(state), 16'd2);
    error = 1'b1;
    frame_done = 1'b1;
    do_sp(1'b1);
    error = 1'b0;
    frame_done = 1'b0;
    check("err_state", 16'(state), 16'd3);
    check("err_f_ovrld", 16'(f_ovrld), 16'd0);
    check("err_oe_type", 16'(oe_type), 16'd0);
    check("err_dec_en", 16'(dec_en), 16'd0);
    @(negedge clk);
    check("err_f_ovrld_hold", 16'(f_ovrld), 16'd0);
    do_sp(1'b1);
    check("oewait_state", 16'(state), 16'd4);
    check("oewait_f_ovrld", 16'(f_ovrld), 16'd1);
    f_itmss = 1'b0;
    do_sp(1'b1);
    f_itmss = 1'b1;
    check("itmss_state", 16'(state), 16'd5);

    // intermission overloads: two allowed, third dominant is a violation
    do_sp(1'b1);
    do_sp(1'b0);
    check("ovl1_state", 16'(state), 16'd3);
    check("ovl1_oe_type", 16'(oe_type), 16'd1);
    check("ovl1_f_ovrld", 16'(f_ovrld), 16'd0);
`ifdef CAN_SEQ_STATS_EN
    check("stat_frames", frame_cnt, 16'd2);
    check("stat_errs", err_cnt, 16'd1);
    check("stat_ovlds", ovld_cnt, 16'd1);
`endif
    do_sp(1'b1);
    f_itmss = 1'b0;
    do_sp(1'b1);
    f_itmss = 1'b1;
    check("ovl1_back_ims", 16'(state), 16'd5);
    do_sp(1'b1);
    do_sp(1'b0);
    check("ovl2_state", 16'(state), 16'd3);
    check("ovl2_oe_type", 16'(oe_type), 16'd1);
    do_sp(1'b1);
    f_itmss = 1'b0;
    do_sp(1'b1);
    f_itmss = 1'b1;
    do_sp(1'b1);
    do_sp(1'b0);
    check("ovl3_integ", 16'(state), 16'd0);

    // frame-maker timeout
    repeat (11) do_sp(1'b1);
    check("re_idle", 16'(state), 16'd1);
    do_sp(1'b0);
    error = 1'b1;
    do_sp(1'b1);
    error = 1'b0;
    do_sp(1'b1);
    check("tout_wait", 16'(state), 16'd4);
    repeat (62) do_sp(1'b1);
    check("tout_62_state", 16'(state), 16'd4);
    check("tout_62_pulse", 16'(oe_tout), 16'd0);
    do_sp(1'b1);
    check("tout_63_state", 16'(state), 16'd0);
    check("tout_63_pulse", 16'(oe_tout), 16'd1);
    @(negedge clk);
    check("tout_pulse_end", 16'(oe_tout), 16'd0);

    // hard sync: dominant in the last intermission bit starts a new frame
    repeat (11) do_sp(1'b1);
    do_sp(1'b0);
    frame_done = 1'b1;
    do_sp(1'b1);
    frame_done = 1'b0;
    do_sp(1'b1);
    do_sp(1'b1);
    do_sp(1'b0);
    check("hsync_state", 16'(state), 16'd2);
    check("hsync_sof", 16'(sof), 16'd1);

    // requested overload at end of frame, then reset mid OE_START
    frame_done = 1'b1;
    ovld_req = 1'b1;
    do_sp(1'b1);
    frame_done = 1'b0;
    ovld_req = 1'b0;
    check("req_ovl_state", 16'(state), 16'd3);
    check("req_ovl_type", 16'(oe_type), 16'd1);
    check("req_ovl_f_ovrld", 16'(f_ovrld), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_f_ovrld", 16'(f_ovrld), 16'd1);
    check("arst_state", 16'(state), 16'd0);
    check("arst_oe_type", 16'(oe_type), 16'd0);
`ifdef CAN_SEQ_STATS_EN
    check("arst_frames", frame_cnt, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
